vector_reduce: RTL and testbench

Downstream consumer of the vector element ALU. It takes the registered result vector S and its length S_len, and reduces the vector sequentially, one element per clock, to a single scalar: wrapping sum, signed max, signed min, or nonzero count. For max and min it also returns the index of the winning element. Start/busy/done handshake toward the command sequencer; the result is held for readback by the host interface.

---
 rtl/vector_reduce_pkg.sv | 17 +
 rtl/vector_reduce_if.sv | 27 ++
 rtl/vector_reduce_step.sv | 33 +++
 rtl/vector_reduce.sv | 107 ++++++++++
 tb/tb_vector_reduce.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/vector_reduce_pkg.sv
// Shared types for the sequential vector reducer: reduction opcodes and FSM states.
package vector_pkg;

    typedef enum logic [1:0] {
        RED_SUM = 2'b00,
        RED_MAX = 2'b01,
        RED_MIN = 2'b10,
        RED_CNT = 2'b11
    } reduce_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } reduce_state_t;

endpackage

// File: rtl/vector_reduce_if.sv
// Command/result bundle between the sequencer (master) and the reducer (slave).
interface vector_reduce_if #(
    parameter int BITS = 8,
    parameter int N    = 64
);
    // Handshake: start is a request sampled only while busy==0; the request is
    // accepted on that clock edge. done pulses once and result/index are valid
    // from that cycle until the next completion. start while busy is dropped.
    logic [N-1:0][BITS-1:0] vec;
    logic [BITS-1:0]        vec_len;
    logic [1:0]             op;
    logic                   start;
    logic                   busy;
    logic                   done;
    logic [BITS-1:0]        result;
    logic [BITS-1:0]        index;

    modport master (
        output vec, vec_len, op, start,
        input  busy, done, result, index
    );

    modport slave (
        input  vec, vec_len, op, start,
        output busy, done, result, index
    );
endinterface

// File: rtl/vector_reduce_step.sv
// One reduction step: folds a single element into the running accumulator.
module reduce_step
    import vector_pkg::*;
#(
    parameter int BITS = 8
) (
    input  logic [BITS-1:0] acc,
    input  logic [BITS-1:0] elem,
    input  reduce_op_t      op,
    output logic [BITS-1:0] next_acc,
    output logic            take
);

    always_comb begin
        next_acc = acc;
        take     = 1'b0;
        case (op)
            RED_SUM: next_acc = acc + elem;
            RED_MAX: begin
                // strict compare so equal values keep the earlier index
                take = $signed(elem) > $signed(acc);
                if (take) next_acc = elem;
            end
            RED_MIN: begin
                take = $signed(elem) < $signed(acc);
                if (take) next_acc = elem;
            end
            RED_CNT: next_acc = acc + BITS'(elem != '0);
            default: next_acc = acc;
        endcase
    end

endmodule

// File: rtl/vector_reduce.sv
// Sequential vector reducer: snapshots a vector on start and folds one element per clock.
module vector_reduce
    import vector_pkg::*;
#(
    parameter int BITS = 8,
    parameter int N    = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    vector_reduce_if.slave bus,
    output reduce_state_t state
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    reduce_state_t          state_next;
    logic [N-1:0][BITS-1:0] snap;
    reduce_op_t             op_q;
    logic [BITS-1:0]        len_q;
    logic [BITS-1:0]        cnt;
    logic [BITS-1:0]        acc;
    logic [BITS-1:0]        idx;
    logic [BITS-1:0]        clamp_len;
    logic [BITS-1:0]        elem;
    logic [BITS-1:0]        next_acc;
    logic                   take;
    logic                   accept;
    logic                   last;
    logic                   is_ext;

    // vec_len can never exceed 2^BITS-1, so the clamped length always fits BITS
    assign clamp_len = ({1'b0, bus.vec_len} > (BITS+1)'(N)) ? BITS'(N) : bus.vec_len;
    assign elem      = snap[cnt[IW-1:0]];
    assign is_ext    = (op_q == RED_MAX) || (op_q == RED_MIN);

    reduce_step #(.BITS(BITS)) u_step (
        .acc      (acc),
        .elem     (elem),
        .op       (op_q),
        .next_acc (next_acc),
        .take     (take)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = (clamp_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt == len_q - BITS'(1)) begin
                    last       = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap       <= '0;
            op_q       <= RED_SUM;
            len_q      <= '0;
            cnt        <= '0;
            acc        <= '0;
            idx        <= '0;
            bus.result <= '0;
            bus.index  <= '0;
        end else if (accept) begin
            snap  <= bus.vec;
            op_q  <= reduce_op_t'(bus.op);
            len_q <= clamp_len;
            cnt   <= '0;
            idx   <= '0;
            acc   <= (bus.op == RED_MAX || bus.op == RED_MIN) ? bus.vec[0] : '0;
            if (clamp_len == '0) begin
                bus.result <= '0;
                bus.index  <= '0;
            end
        end else if (state == RUN) begin
            cnt <= cnt + BITS'(1);
            acc <= next_acc;
            if (take) idx <= cnt;
            // outputs change only on the final element, never mid-reduction
            if (last) begin
                bus.result <= next_acc;
                bus.index  <= is_ext ? (take ? cnt : idx) : '0;
            end
        end
    end

endmodule

// File: tb/tb_vector_reduce.sv
// Directed bench for vector_reduce: hand-computed vectors, timing, handshake and reset cases.
module tb_vector_reduce;
    import vector_pkg::*;

    localparam int BITS = 8;
    localparam int N    = 8;

    typedef logic [N-1:0][BITS-1:0] vec_t;

    logic          clk;
    logic          rst_n;
    reduce_state_t dbg_state;
    int            n_vec;
    int            n_err;
    logic [BITS-1:0] exp_q[$];

    vector_reduce_if #(.BITS(BITS), .N(N)) bus ();

    vector_reduce #(.BITS(BITS), .N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7);
        return {a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    // Drive one reduction and watch it to completion; expected values go through exp_q.
    task automatic run_vec(input string tag, input vec_t v, input logic [7:0] len,
                           input logic [1:0] o, input logic [7:0] exp_res,
                           input logic [7:0] exp_idx, input int exp_lat,
                           input bit mid_start, input bit mid_change);
        int lat   = 0;
        int nbusy = 0;
        int ndone = 0;
        logic [7:0] got_res = '0;
        logic [7:0] got_idx = '0;
        logic [7:0] er;
        logic [7:0] ei;
        exp_q.push_back(exp_res);
        exp_q.push_back(exp_idx);
        @(negedge clk);
        bus.vec     = v;
        bus.vec_len = len;
        bus.op      = o;
        bus.start   = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.busy) nbusy++;
            if (bus.done) begin
                ndone++;
                if (lat == 0) begin
                    lat     = c;
                    got_res = bus.result;
                    got_idx = bus.index;
                end
            end
            if (c == 1) begin
                bus.start = 1'b0;
                if (mid_change) begin
                    bus.vec     = {N{8'h55}};
                    bus.vec_len = 8'd0;
                    bus.op      = 2'b01;
                end
            end
            if (mid_start && c == 2) bus.start = 1'b1;
            if (mid_start && c == 3) bus.start = 1'b0;
            if (lat != 0 && c >= lat + 3) break;
        end
        er = exp_q.pop_front();
        ei = exp_q.pop_front();
        check_eq({tag, "_result"}, got_res, er);
        check_eq({tag, "_index"}, got_idx, ei);
        check_eq({tag, "_latency"}, lat, exp_lat);
        check_eq({tag, "_busy_cycles"}, nbusy, exp_lat);
        check_eq({tag, "_done_pulses"}, ndone, 1);
        check_eq({tag, "_held_result"}, bus.result, er);
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        bus.vec     = '0;
        bus.vec_len = '0;
        bus.op      = 2'b00;
        bus.start   = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_busy", bus.busy, 0);
        check_eq("reset_done", bus.done, 0);
        check_eq("reset_result", bus.result, 0);
        check_eq("reset_index", bus.index, 0);
        check_eq("reset_state", dbg_state, IDLE);
        rst_n = 1'b1;

        run_vec("sum4", mk(1, 2, 3, 4, 9, 9, 9, 9), 8'd4, 2'b00, 8'd10, 8'd0, 5, 1'b0, 1'b0);
        run_vec("wrap", mk(100, 100, 100, 100, 100, 100, 100, 100), 8'd3, 2'b00, 8'd44, 8'd0, 4, 1'b0, 1'b0);
        run_vec("max_tie", mk(5, 8'hFD, 127, 127, 0, 0, 0, 0), 8'd4, 2'b01, 8'd127, 8'd2, 5, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a reduction.
        @(negedge clk);
        bus.vec     = mk(1, 2, 3, 4, 5, 6, 7, 8);
        bus.vec_len = 8'd8;
        bus.op      = 2'b00;
        bus.start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check_eq("midrst_busy_before", bus.busy, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_busy", bus.busy, 0);
        check_eq("midrst_done", bus.done, 0);
        check_eq("midrst_result", bus.result, 0);
        check_eq("midrst_index", bus.index, 0);
        check_eq("midrst_state", dbg_state, IDLE);
        @(negedge clk);
        rst_n = 1'b1;

        run_vec("min", mk(5, 8'hFD, 127, 127, 0, 0, 0, 0), 8'd4, 2'b10, 8'hFD, 8'd1, 5, 1'b0, 1'b0);
        run_vec("empty", mk(5, 8'hFD, 127, 127, 0, 0, 0, 0), 8'd0, 2'b10, 8'd0, 8'd0, 1, 1'b0, 1'b0);
        run_vec("cnt_clamp", mk(0, 1, 0, 2, 0, 3, 0, 4), 8'd200, 2'b11, 8'd4, 8'd0, 9, 1'b0, 1'b0);
        run_vec("snap_midstart", mk(1, 2, 3, 4, 5, 6, 7, 8), 8'd8, 2'b00, 8'd36, 8'd0, 9, 1'b1, 1'b1);
        run_vec("min_alltie", mk(8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80), 8'd8, 2'b10,
                8'h80, 8'd0, 9, 1'b0, 1'b0);
        run_vec("max_last", mk(8'hF0, 8'h81, 0, 3, 8'hFF, 2, 1, 7), 8'd8, 2'b01, 8'd7, 8'd7, 9, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
